load_store_unit: RTL and testbench

Sequential adapter between the core's execute stage and the word-organised data `Memory`. It accepts byte-addressed RV32I load/store requests (LB/LH/LW/LBU/LHU/SB/SH/SW). For each request it:
- drives `Memory`'s word-indexed read/write port;
- performs read-modify-write for sub-word stores;
- sign- or zero-extends load data;
- reports misaligned or out-of-range accesses as errors without touching memory.

---
 rtl/load_store_unit_pkg.sv | 28 ++
 rtl/load_store_unit_if.sv | 31 +++
 rtl/load_store_unit_align.sv | 54 +++++
 rtl/load_store_unit.sv | 99 +++++++++
 tb/tb_load_store_unit.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/load_store_unit_pkg.sv
// rtl/load_store_unit_pkg.sv - shared funct3 codes, FSM encoding and request legality helper
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_READ  = 2'b01,
    ST_WRITE = 2'b10,
    ST_RESP  = 2'b11
  } lsu_state_e;

  // Stores have no unsigned variants, so BU/HU are only legal for loads.
  function automatic logic f3_legal(input logic is_write, input logic [2:0] f3);
    logic ok;
    case (f3)
      F3_B, F3_H, F3_W: ok = 1'b1;
      F3_BU, F3_HU:     ok = ~is_write;
      default:          ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// rtl/load_store_unit_if.sv - core request/response and word-memory port bundle
interface load_store_unit_if;

  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [2:0]  req_funct3;
  logic [31:0] req_address;
  logic [31:0] req_write_data;
  logic        resp_valid;
  logic [31:0] resp_read_data;
  logic        resp_error;
  logic        memory_read;
  logic        memory_write;
  logic [31:0] address;
  logic [31:0] write_data;
  logic [31:0] read_data;

  modport slave (
    input  req_valid, req_write, req_funct3, req_address, req_write_data, read_data,
    output req_ready, resp_valid, resp_read_data, resp_error,
           memory_read, memory_write, address, write_data
  );

  modport master (
    output req_valid, req_write, req_funct3, req_address, req_write_data, read_data,
    input  req_ready, resp_valid, resp_read_data, resp_error,
           memory_read, memory_write, address, write_data
  );

endinterface

// File: rtl/load_store_unit_align.sv
// rtl/load_store_unit_align.sv - byte/halfword lane extraction, load extension and store merge
module lsu_align
  import lsu_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] store_data_i,
  output logic [31:0] load_data_o,
  output logic [31:0] store_word_o,
  output logic        misaligned_o
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  always_comb begin
    lane_b       = word_i[{addr_lo_i, 3'b000} +: 8];
    lane_h       = addr_lo_i[1] ? word_i[31:16] : word_i[15:0];
    load_data_o  = '0;
    store_word_o = word_i;
    misaligned_o = 1'b0;
    case (funct3_i)
      F3_B: begin
        load_data_o = {{24{lane_b[7]}}, lane_b};
        store_word_o[{addr_lo_i, 3'b000} +: 8] = store_data_i[7:0];
      end
      F3_H: begin
        load_data_o  = {{16{lane_h[15]}}, lane_h};
        misaligned_o = addr_lo_i[0];
        if (addr_lo_i[1]) begin
          store_word_o[31:16] = store_data_i[15:0];
        end else begin
          store_word_o[15:0]  = store_data_i[15:0];
        end
      end
      F3_W: begin
        load_data_o  = word_i;
        store_word_o = store_data_i;
        misaligned_o = |addr_lo_i;
      end
      F3_BU: begin
        load_data_o = {24'h0, lane_b};
      end
      F3_HU: begin
        load_data_o  = {16'h0, lane_h};
        misaligned_o = addr_lo_i[0];
      end
      default: begin
      end
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - sequential RV32I load/store adapter onto a word-indexed memory port
module load_store_unit #(
  parameter int unsigned MEMORY_SIZE = 4096
) (
  input  logic              clk,
  input  logic              reset,
  load_store_unit_if.slave  bus
);

  import lsu_pkg::*;

  lsu_state_e  state_q;
  logic        write_q;
  logic [2:0]  f3_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] word_q;
  logic        err_q;

  logic        idle;
  logic [1:0]  align_addr;
  logic [2:0]  align_f3;
  logic [31:0] load_data;
  logic [31:0] store_word;
  logic        misaligned;
  logic        req_err;

  assign idle = (state_q == ST_IDLE);

  // In IDLE the aligner checks the incoming request; afterwards it works on the latched one.
  assign align_addr = idle ? bus.req_address[1:0] : addr_q[1:0];
  assign align_f3   = idle ? bus.req_funct3       : f3_q;

  lsu_align u_align (
    .word_i       (word_q),
    .addr_lo_i    (align_addr),
    .funct3_i     (align_f3),
    .store_data_i (wdata_q),
    .load_data_o  (load_data),
    .store_word_o (store_word),
    .misaligned_o (misaligned)
  );

  assign req_err = misaligned
                 | ~f3_legal(bus.req_write, bus.req_funct3)
                 | (bus.req_address >= MEMORY_SIZE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      write_q <= 1'b0;
      f3_q    <= 3'b000;
      addr_q  <= '0;
      wdata_q <= '0;
      word_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.req_valid) begin
            write_q <= bus.req_write;
            f3_q    <= bus.req_funct3;
            addr_q  <= bus.req_address;
            wdata_q <= bus.req_write_data;
            err_q   <= req_err;
            if (req_err) begin
              state_q <= ST_RESP;
            end else if (bus.req_write && (bus.req_funct3 == F3_W)) begin
              state_q <= ST_WRITE;
            end else begin
              state_q <= ST_READ;
            end
          end
        end
        ST_READ: begin
          word_q  <= bus.read_data;
          state_q <= write_q ? ST_WRITE : ST_RESP;
        end
        ST_WRITE: begin
          state_q <= ST_RESP;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // Memory strobes are pure state decodes so reset removes them without waiting for an edge.
  assign bus.req_ready      = idle;
  assign bus.memory_read    = (state_q == ST_READ);
  assign bus.memory_write   = (state_q == ST_WRITE);
  assign bus.address        = (bus.memory_read || bus.memory_write) ? {2'b00, addr_q[31:2]} : '0;
  assign bus.write_data     = bus.memory_write ? store_word : '0;
  assign bus.resp_valid     = (state_q == ST_RESP);
  assign bus.resp_error     = bus.resp_valid & err_q;
  assign bus.resp_read_data = (bus.resp_valid && !err_q && !write_q) ? load_data : '0;

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - randomized self-checking bench with a byte-level reference memory
module tb_load_store_unit;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic preload_en = 1'b0;
  int   total = 0;
  int   bad = 0;

  logic [31:0] mem     [0:1023];
  logic [31:0] pre     [0:1023];
  logic [31:0] ref_mem [0:1023];

  load_store_unit_if bus ();

  load_store_unit #(.MEMORY_SIZE(4096)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  assign bus.read_data = mem[bus.address[9:0]];

  always @(posedge clk) begin
    if (preload_en) begin
      for (int i = 0; i < 1024; i++) mem[i] <= pre[i];
    end else if (bus.memory_write) begin
      mem[bus.address[9:0]] <= bus.write_data;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic int acc_size(input logic [2:0] f3);
    if (f3[1:0] == 2'b00) return 1;
    if (f3[1:0] == 2'b01) return 2;
    return 4;
  endfunction

  function automatic logic is_err(input logic wr, input logic [2:0] f3, input logic [31:0] a);
    logic legal;
    legal = wr ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    return !legal || ((a % 32'(acc_size(f3))) != 0) || (a >= 32'd4096);
  endfunction

  function automatic logic [31:0] ext_load(input logic [2:0] f3, input logic [31:0] w, input logic [31:0] a);
    logic [31:0] b;
    logic [31:0] h;
    b = (w >> (8 * (a % 4))) & 32'hFF;
    h = (w >> (8 * (a % 4))) & 32'hFFFF;
    case (f3)
      3'd0:    return (b >= 32'd128)   ? b + 32'hFFFFFF00 : b;
      3'd1:    return (h >= 32'd32768) ? h + 32'hFFFF0000 : h;
      3'd2:    return w;
      3'd4:    return b;
      3'd5:    return h;
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] merge(input logic [2:0] f3, input logic [31:0] w, input logic [31:0] d, input logic [31:0] a);
    logic [31:0] mask;
    logic [31:0] sh;
    sh = 8 * (a % 4);
    if (acc_size(f3) == 4) mask = 32'hFFFFFFFF;
    else if (acc_size(f3) == 2) mask = 32'h0000FFFF << sh;
    else mask = 32'h000000FF << sh;
    return (w & ~mask) | ((d << sh) & mask);
  endfunction

  task automatic scramble(input logic valid);
    bus.req_valid      = valid;
    bus.req_write      = 1'($urandom);
    bus.req_funct3     = 3'($urandom);
    bus.req_address    = $urandom;
    bus.req_write_data = $urandom;
  endtask

  // Called at a negedge with the unit idle; returns at a negedge with the unit idle again.
  task automatic run_req(input logic wr, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
    logic        e;
    logic        got;
    logic [31:0] exp_rd;
    logic [31:0] exp_wd;
    int          exp_lat;
    int          n;
    int          reads;
    int          writes;
    e       = is_err(wr, f3, a);
    exp_lat = e ? 1 : (wr && f3 == 3'd2) ? 2 : wr ? 3 : 2;
    exp_rd  = (e || wr) ? 32'h0 : ext_load(f3, ref_mem[a[11:2]], a);
    exp_wd  = merge(f3, ref_mem[a[11:2]], d, a);
    check("ready_before", 32'(bus.req_ready), 32'd1);
    bus.req_valid      = 1'b1;
    bus.req_write      = wr;
    bus.req_funct3     = f3;
    bus.req_address    = a;
    bus.req_write_data = d;
    @(posedge clk);
    #1 scramble(1'b0);
    n = 0; got = 1'b0; reads = 0; writes = 0;
    while (n < 6 && !got) begin
      @(negedge clk);
      n++;
      if (bus.memory_read) begin
        reads++;
        check("rd_addr", bus.address, a >> 2);
      end
      if (bus.memory_write) begin
        writes++;
        check("wr_addr", bus.address, a >> 2);
        check("wr_data", bus.write_data, exp_wd);
      end
      if (bus.resp_valid) got = 1'b1;
    end
    check("latency", got ? 32'(n) : 32'd99, 32'(exp_lat));
    check("busy_in_resp", 32'(bus.req_ready), 32'd0);
    check("resp_err", 32'(bus.resp_error), 32'(e));
    check("resp_data", bus.resp_read_data, exp_rd);
    check("reads", 32'(reads), (!e && !(wr && f3 == 3'd2)) ? 32'd1 : 32'd0);
    check("writes", 32'(writes), (!e && wr) ? 32'd1 : 32'd0);
    if (!e && wr) ref_mem[a[11:2]] = exp_wd;
    @(negedge clk);
    check("ready_after", 32'(bus.req_ready), 32'd1);
    check("no_resp_after", 32'(bus.resp_valid), 32'd0);
  endtask

  task automatic reset_during_sb();
    int n;
    bus.req_valid      = 1'b1;
    bus.req_write      = 1'b1;
    bus.req_funct3     = 3'd0;
    bus.req_address    = 32'h5;
    bus.req_write_data = 32'h00000077;
    @(posedge clk);
    #1 scramble(1'b0);
    n = 0;
    while (n < 5 && !bus.memory_write) begin
      @(negedge clk);
      n++;
    end
    check("sb_write_cycle", 32'(n), 32'd2);
    reset = 1'b0;
    #1;
    check("rst_wr_drop", 32'(bus.memory_write), 32'd0);
    check("rst_addr_zero", bus.address, 32'h0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_no_resp", 32'(bus.resp_valid), 32'd0);
    end
    reset = 1'b1;
    #1;
    check("rst_ready", 32'(bus.req_ready), 32'd1);
    check("rst_word1", mem[1], 32'h8899AABB);
    @(negedge clk);
  endtask

  task automatic back_to_back();
    logic [2:0]  f3s [4];
    logic [31:0] as  [4];
    logic [31:0] expq [$];
    int idx;
    int done;
    int last;
    f3s = '{3'd0, 3'd4, 3'd5, 3'd2};
    as  = '{32'h5, 32'h5, 32'h6, 32'h4};
    idx = 0; done = 0; last = 0;
    for (int cyc = 0; cyc < 40 && done < 4; cyc++) begin
      if (bus.resp_valid) begin
        check("b2b_data", bus.resp_read_data, (expq.size() > 0) ? expq.pop_front() : 32'hBAD0BAD0);
        done++;
      end
      if (bus.req_ready && idx < 4) begin
        bus.req_valid      = 1'b1;
        bus.req_write      = 1'b0;
        bus.req_funct3     = f3s[idx];
        bus.req_address    = as[idx];
        bus.req_write_data = $urandom;
        expq.push_back(ext_load(f3s[idx], ref_mem[as[idx][11:2]], as[idx]));
        if (idx > 0) check("b2b_gap", 32'(cyc - last), 32'd3);
        last = cyc;
        idx++;
      end else begin
        scramble(idx < 4);
      end
      @(negedge clk);
    end
    check("b2b_done", 32'(done), 32'd4);
    bus.req_valid = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    logic        wr;
    logic [2:0]  f3;
    logic [31:0] a;
    bus.req_valid      = 1'b0;
    bus.req_write      = 1'b0;
    bus.req_funct3     = 3'd0;
    bus.req_address    = 32'h0;
    bus.req_write_data = 32'h0;
    for (int i = 0; i < 1024; i++) begin
      pre[i]     = $urandom;
      ref_mem[i] = pre[i];
    end
    pre[1]     = 32'h8899AABB;
    ref_mem[1] = 32'h8899AABB;
    preload_en = 1'b1;
    @(negedge clk);
    check("rst_req_ready", 32'(bus.req_ready), 32'd1);
    check("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    check("rst_resp_error", 32'(bus.resp_error), 32'd0);
    check("rst_resp_data", bus.resp_read_data, 32'h0);
    check("rst_mem_read", 32'(bus.memory_read), 32'd0);
    check("rst_mem_write", 32'(bus.memory_write), 32'd0);
    check("rst_address", bus.address, 32'h0);
    check("rst_write_data", bus.write_data, 32'h0);
    @(negedge clk);
    preload_en = 1'b0;
    reset = 1'b1;
    @(negedge clk);

    run_req(1'b0, 3'd0, 32'h5, 32'h0);
    run_req(1'b0, 3'd4, 32'h5, 32'h0);
    run_req(1'b0, 3'd5, 32'h6, 32'h0);
    reset_during_sb();
    run_req(1'b0, 3'd2, 32'h4, 32'h0);
    run_req(1'b1, 3'd1, 32'h6, 32'h00001234);
    run_req(1'b0, 3'd2, 32'h4, 32'h0);
    check("sh_word1", ref_mem[1], 32'h1234AABB);
    run_req(1'b1, 3'd2, 32'h4, 32'hDEADBEEF);
    run_req(1'b0, 3'd2, 32'h6, 32'h0);
    run_req(1'b0, 3'd1, 32'h5, 32'h0);
    run_req(1'b0, 3'd3, 32'h4, 32'h0);
    run_req(1'b1, 3'd2, 32'h1000, 32'h12345678);
    back_to_back();

    for (int k = 0; k < 60; k++) begin
      wr = 1'($urandom);
      f3 = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 5) == 0) a = 32'h0FF8 + 32'($urandom_range(0, 15));
      else a = 32'($urandom_range(0, 63));
      run_req(wr, f3, a, $urandom);
    end

    for (int i = 0; i < 16; i++) check("final_mem", mem[i], ref_mem[i]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
